// File: rtl/pulse_shaper_pkg.sv
// Shared constants for the pulse shaper: FSM state encodings and default widths.
package pulse_shaper_pkg;

    localparam int unsigned CNT_WIDTH_DEF    = 32;
    localparam int unsigned MISSED_WIDTH_DEF = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] HIGH  = 2'd2;

endpackage

// File: rtl/pulse_shaper_counter.sv
// Loadable down-counter shared by the DELAY and HIGH phases; holds at zero.
module pulse_shaper_counter
    import pulse_shaper_pkg::*;
#(
    parameter int unsigned W = CNT_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/pulse_shaper.sv
// Pulse shaper: turns a one-cycle trigger into a delayed level pulse of
// programmable width and counts triggers dropped while busy.
// Optional build macro PULSE_SHAPER_RETRIGGER_EN: a trigger during the high
// phase restarts the high phase with the current width instead of being dropped.
module pulse_shaper
    import pulse_shaper_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int unsigned MISSED_WIDTH = MISSED_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig,
    input  logic [CNT_WIDTH-1:0]    delay,
    input  logic [CNT_WIDTH-1:0]    width,
    input  logic                    missed_clr,
    output logic                    dout,
    output logic                    busy,
    output logic                    done,
    output logic [MISSED_WIDTH-1:0] missed_cnt
);

    logic [1:0]           state_q;
    logic [1:0]           state_nxt;
    logic [CNT_WIDTH-1:0] width_q;
    logic [CNT_WIDTH-1:0] cnt_val;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 cnt_tc_c;
    logic                 width_ld;
    logic                 miss_inc;
    logic                 dout_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;

    pulse_shaper_counter #(.W(CNT_WIDTH)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .tc_c     (cnt_tc_c)
    );

    // State register plus width captured at trigger acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            width_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (width_ld) begin
                width_q <= width;
            end
        end
    end

    // Next state, counter control and next values of the registered outputs.
    always_comb begin
        state_nxt = state_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_val   = '0;
        width_ld  = 1'b0;
        miss_inc  = 1'b0;
        dout_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_nxt = DELAY;
                    cnt_load  = 1'b1;
                    cnt_val   = delay;
                    width_ld  = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            DELAY: begin
                miss_inc = trig;
                if (cnt_tc_c) begin
                    if (width_q == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        // Entering HIGH is itself the first high cycle.
                        state_nxt = HIGH;
                        cnt_load  = 1'b1;
                        cnt_val   = width_q - CNT_WIDTH'(1);
                        dout_nxt  = 1'b1;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    cnt_en   = 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            HIGH: begin
`ifdef PULSE_SHAPER_RETRIGGER_EN
                if (trig) begin
                    // Edge R keeps dout high, then width further cycles follow.
                    cnt_load = 1'b1;
                    cnt_val  = width;
                    dout_nxt = 1'b1;
                    busy_nxt = 1'b1;
                end else if (cnt_tc_c) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_en   = 1'b1;
                    dout_nxt = 1'b1;
                    busy_nxt = 1'b1;
                end
`else
                miss_inc = trig;
                if (cnt_tc_c) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_en   = 1'b1;
                    dout_nxt = 1'b1;
                    busy_nxt = 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs and saturating missed-trigger counter (clear wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            missed_cnt <= '0;
        end else begin
            dout <= dout_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
            if (missed_clr) begin
                missed_cnt <= '0;
            end else if (miss_inc && (missed_cnt != '1)) begin
                missed_cnt <= missed_cnt + MISSED_WIDTH'(1);
            end
        end
    end

endmodule
